spi_flash_rd_seq: RTL

//  Sequencer for spi_master that runs serial-flash READ transactions.
//  - Takes one host command (address, byte count).
//  - Programs spi_master, pushes opcode + 24-bit address into its write port.
//  - Drains read bytes from its read port to a ready/valid byte stream.
//  - Sits between host/DMA logic and spi_master; single clock domain.
//  - Integration: spi_master wr_clk/rd_clk = rd_clk, SSIZE=1, CSNUM=8.

---
 rtl/spi_flash_rd_seq.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_rd_seq.sv
// Serial-flash READ sequencer in front of spi_master.
// One host command becomes opcode + 24-bit address out, then a byte stream back.
module spi_flash_rd_seq #(
  parameter logic [7:0]  RD_OPCODE = 8'h03,
  parameter logic [2:0]  REQ_CMD   = 3'd1,
  parameter logic [23:0] MAX_LEN   = 24'hFFFFFB,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        rd_clk,
  input  logic        rd_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_addr,
  input  logic [23:0] cmd_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        done,
  output logic        err,
  output logic        m_request,
  output logic [2:0]  m_req_cmd,
  output logic [23:0] m_req_len,
  output logic [23:0] m_req_wr_len,
  input  logic        m_busy,
  input  logic        m_finish,
  output logic        m_wr_en,
  output logic        m_wr_vld,
  output logic [7:0]  m_wr_data,
  input  logic        m_wr_ready,
  output logic        m_rd_en,
  output logic        m_rd_ready,
  input  logic        m_rd_vld,
  input  logic [7:0]  m_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SEND,
    S_RECV,
    S_FIN
  } state_t;

  localparam logic [31:0] TO_LAST = TIMEOUT - 32'd1;

  state_t      state_q;
  state_t      state_n;
  logic [23:0] addr_q;
  logic [23:0] req_len_q;
  logic [23:0] rem_q;
  logic [23:0] rx_left_q;
  logic [1:0]  idx_q;
  logic        full_q;
  logic [7:0]  data_q;
  logic        fin_seen_q;
  logic [31:0] to_cnt_q;
  logic        done_q;
  logic        err_q;
  logic        done_n;
  logic        err_n;

  logic accept;
  logic len_ok;
  logic wr_hs;
  logic rd_hs;
  logic out_hs;
  logic active;
  logic activity;
  logic to_hit;
  logic unused_busy;

  assign unused_busy = m_busy;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign len_ok    = (cmd_len != 24'd0) && (cmd_len <= MAX_LEN);

  assign m_request    = (state_q == S_REQ);
  assign m_req_cmd    = REQ_CMD;
  assign m_req_len    = req_len_q;
  assign m_req_wr_len = 24'd4;

  assign m_wr_en  = (state_q != S_IDLE);
  assign m_wr_vld = (state_q == S_SEND);
  assign m_rd_en  = (state_q == S_RECV);

  // rx_left gate keeps a chatty master from pushing past the request
  assign m_rd_ready = m_rd_en
                    & (rx_left_q != 24'd0)
                    & (~full_q | out_ready);

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign out_last  = full_q & (rem_q == 24'd1);
  assign done      = done_q;
  assign err       = err_q;

  assign wr_hs  = m_wr_vld & m_wr_ready;
  assign rd_hs  = m_rd_vld & m_rd_ready;
  assign out_hs = full_q & out_ready;

  assign active = (state_q == S_SEND)
                | (state_q == S_RECV)
                | (state_q == S_FIN);

  assign activity = wr_hs | rd_hs | out_hs | m_finish;

  assign to_hit = (TIMEOUT != 0)
                & active
                & ~activity
                & (to_cnt_q == TO_LAST);

  always_comb begin
    m_wr_data = 8'h00;
    if (state_q == S_SEND) begin
      unique case (idx_q)
        2'd0:    m_wr_data = RD_OPCODE;
        2'd1:    m_wr_data = addr_q[23:16];
        2'd2:    m_wr_data = addr_q[15:8];
        default: m_wr_data = addr_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_n = state_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (len_ok) begin
            state_n = S_REQ;
          end else begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end
        end
      end
      S_REQ: state_n = S_SEND;
      S_SEND: begin
        if (wr_hs && idx_q == 2'd3)
          state_n = S_RECV;
      end
      S_RECV: begin
        if (out_hs && rem_q == 24'd1)
          state_n = S_FIN;
      end
      S_FIN: begin
        if (fin_seen_q | m_finish) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (to_hit) begin
      state_n = S_IDLE;
      done_n  = 1'b1;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      addr_q     <= 24'd0;
      req_len_q  <= 24'd0;
      rem_q      <= 24'd0;
      rx_left_q  <= 24'd0;
      idx_q      <= 2'd0;
      full_q     <= 1'b0;
      data_q     <= 8'h00;
      fin_seen_q <= 1'b0;
      to_cnt_q   <= 32'd0;
    end else begin
      if (accept) begin
        addr_q     <= cmd_addr;
        rem_q      <= cmd_len;
        rx_left_q  <= cmd_len;
        idx_q      <= 2'd0;
        fin_seen_q <= 1'b0;
        if (len_ok)
          req_len_q <= cmd_len + 24'd4;
      end
      if (wr_hs)
        idx_q <= idx_q + 2'd1;
      if (rd_hs) begin
        data_q    <= m_rd_data;
        rx_left_q <= rx_left_q - 24'd1;
      end
      if (out_hs)
        rem_q <= rem_q - 24'd1;
      if (to_hit)
        full_q <= 1'b0;
      else
        full_q <= rd_hs | (full_q & ~out_ready);
      // finish may beat the last byte out of the skid register
      if (m_finish && state_q != S_IDLE)
        fin_seen_q <= 1'b1;
      if (!active || activity)
        to_cnt_q <= 32'd0;
      else
        to_cnt_q <= to_cnt_q + 32'd1;
    end
  end

endmodule
